logic_unit_seq: RTL and testbench



---
 rtl/logic_unit_seq.sv | 140 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per cycle, valid/ready on both sides.
// Optional registered zero flag is built when LOGIC_UNIT_ZERO_EN is defined.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
`ifdef LOGIC_UNIT_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] res_r;
    logic             in_ready_r;
    logic             out_valid_r;
`ifdef LOGIC_UNIT_ZERO_EN
    logic             zero_r;
`endif

    int               idx_s;
    logic [SLICE-1:0] slice_s;
    logic [WIDTH-1:0] next_res_s;

    function automatic logic [SLICE-1:0] slice_op(input logic [1:0] o,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
        logic [SLICE-1:0] r;
        case (o)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            2'b11:   r = ~(x | y);
            default: r = {SLICE{1'b0}};
        endcase
        return r;
    endfunction

    // Slice selected by the counter and the result with that slice merged in
    always_comb begin
        idx_s      = int'(cnt_r) * SLICE;
        slice_s    = slice_op(op_r, a_r[idx_s +: SLICE], b_r[idx_s +: SLICE]);
        next_res_s = res_r;
        next_res_s[idx_s +: SLICE] = slice_s;
    end

    // Control FSM with registered handshake outputs and result datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 2'b00;
            res_r       <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef LOGIC_UNIT_ZERO_EN
            zero_r      <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        op_r       <= op;
                        res_r      <= {WIDTH{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    res_r <= next_res_s;
                    if (cnt_r == LAST) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
`ifdef LOGIC_UNIT_ZERO_EN
                        zero_r      <= (next_res_s == {WIDTH{1'b0}});
`endif
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    // No bypass: in_ready only rises once back in IDLE
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CW{1'b0}};
                    res_r       <= {WIDTH{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign res       = res_r;
`ifdef LOGIC_UNIT_ZERO_EN
    assign zero      = zero_r;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: a 32/8 instance and a 16/16 (single-slice) instance.
// Zero-flag checks are compiled in when LOGIC_UNIT_ZERO_EN is defined.
module tb_logic_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, in_ready, out_valid;
    logic [31:0] a, b, res;
    logic [1:0]  op;
    logic        in_valid1, out_ready1, in_ready1, out_valid1;
    logic [15:0] a1, b1, res1;
    logic [1:0]  op1;
`ifdef LOGIC_UNIT_ZERO_EN
    logic        zero, zero1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .res(res)
`ifdef LOGIC_UNIT_ZERO_EN
        , .zero(zero)
`endif
    );

    logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1), .res(res1)
`ifdef LOGIC_UNIT_ZERO_EN
        , .zero(zero1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word bitwise result, truncated to w bits
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (o)
            2'd0:    r = {32'd0, x & y};
            2'd1:    r = {32'd0, x | y};
            2'd2:    r = {32'd0, x ^ y};
            default: r = {32'd0, ~(x | y)};
        endcase
        m = (64'd1 << w) - 64'd1;
        return 32'(r & m);
    endfunction

    // One transaction on the 32/8 unit; starts and ends at a falling edge
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int stall, input bit scramble);
        logic [31:0] exp;
        int cyc;
        exp = model(o, av, bv, 32);
        a = av; b = bv; op = o; in_valid = 1'b1; out_ready = (stall == 0);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            check("run_busy", 32'(in_ready), 32'd0);
            if (scramble) begin
                a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 32'(cyc), 32'd5);
        check("result", res, exp);
`ifdef LOGIC_UNIT_ZERO_EN
        check("zero_flag", 32'(zero), 32'(exp == 32'd0));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = ~av;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_res", res, exp);
            check("hold_no_accept", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("back_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
        out_ready = 1'b0;
    endtask

    // One transaction on the single-slice 16/16 unit
    task automatic run_op16(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv);
        logic [31:0] exp;
        int cyc;
        exp = model(o, {16'd0, av}, {16'd0, bv}, 16);
        a1 = av; b1 = bv; op1 = o; in_valid1 = 1'b1; out_ready1 = 1'b1;
        check("n1_accept_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 1;
        while (out_valid1 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("n1_latency", 32'(cyc), 32'd2);
        check("n1_result", {16'd0, res1}, exp);
`ifdef LOGIC_UNIT_ZERO_EN
        check("n1_zero_flag", 32'(zero1), 32'(exp == 32'd0));
`endif
        @(negedge clk);
        check("n1_back_to_idle", {30'd0, in_ready1, out_valid1}, 32'd2);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; op = 2'd0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 16'd0; b1 = 16'd0; op1 = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res", res, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_n1_res", {16'd0, res1}, 32'd0);
`ifdef LOGIC_UNIT_ZERO_EN
        check("rst_zero", 32'(zero), 32'd1);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Directed ops on the reference operands
        run_op(2'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b0);
        run_op(2'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b0);
        run_op(2'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b1);
        run_op(2'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b0);

        // Backpressure with a zero result
        run_op(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 10, 1'b0);

        // Reset in the middle of RUN discards the partial result
        a = 32'hFFFF_FFFF; b = 32'h1234_5678; op = 2'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_rst_res", res, 32'd0);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_UNIT_ZERO_EN
        check("midrun_rst_zero", 32'(zero), 32'd1);
`endif
        run_op(2'd0, 32'hCAFE_F00D, 32'h0F0F_0F0F, 0, 1'b0);

        // Randomized ops with scrambled inputs during RUN and random backpressure
        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        // Single-slice configuration
        run_op16(2'd1, 16'hAAAA, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            run_op16(2'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
